// File: rtl/wb_port_arbiter_if.sv
// Signal bundle around the single register-file write port: pipeline writeback,
// long-latency result offer, decode hazard inputs and the arbitrated RF write.
interface wb_port_arbiter_if;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic        RegWriteD;
  logic [4:0]  WriteRegD;
  logic        StallD;
  logic        StallW;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output RegWriteW, WriteRegW, ResultW, md_valid, md_reg, md_data,
           issue_valid, issue_reg, RsD, RtD, RegWriteD, WriteRegD,
    input  md_ready, StallD, StallW, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  RegWriteW, WriteRegW, ResultW, md_valid, md_reg, md_data,
           issue_valid, issue_reg, RsD, RtD, RegWriteD, WriteRegD,
    output md_ready, StallD, StallW, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one RF write port between the writeback stage and a 2-entry mul/div result
// FIFO, with starvation forcing and a pending-register scoreboard for decode stalls.
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic            live_q;
  logic [4:0]      ent_reg_q  [2];
  logic [31:0]     ent_data_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;

  logic            fifo_empty, fifo_full, force_head, grant_fifo, push, issue_set, stall_dec;
  logic [4:0]      head_reg, waddr;
  logic [31:0]     head_data;

  always_comb begin
    fifo_empty = (count_q == 2'd0);
    fifo_full  = (count_q == 2'd2);
    force_head = (starve_q == STARVE_LIM);
    grant_fifo = !fifo_empty && (!bus.RegWriteW || force_head);
    push       = bus.md_valid && live_q && !fifo_full;
    head_reg   = ent_reg_q[rd_ptr_q];
    head_data  = ent_data_q[rd_ptr_q];
    waddr      = grant_fifo ? head_reg : bus.WriteRegW;

    // Bit 0 of pending_q is never set, so register 0 cannot stall.
    stall_dec  = live_q && (pending_q[bus.RsD] || pending_q[bus.RtD] ||
                 (bus.RegWriteD && pending_q[bus.WriteRegD]) ||
                 (bus.issue_valid && pending_q[bus.issue_reg]));
    issue_set  = bus.issue_valid && !stall_dec && (bus.issue_reg != 5'd0);

    pending_d = pending_q;
    if (grant_fifo) pending_d[head_reg] = 1'b0;
    if (issue_set)  pending_d[bus.issue_reg] = 1'b1;
    pending_d[0] = 1'b0;

    case ({push, grant_fifo})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (fifo_empty || grant_fifo)  starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + CW'(1);
    else                           starve_d = starve_q;
  end

  assign bus.md_ready = live_q && !fifo_full;
  assign bus.StallD   = stall_dec;
  assign bus.StallW   = !fifo_empty && bus.RegWriteW && force_head;
  assign bus.rf_waddr = waddr;
  assign bus.rf_wdata = grant_fifo ? head_data : bus.ResultW;
  assign bus.rf_we    = live_q && (grant_fifo || bus.RegWriteW) && (waddr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q        <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      starve_q      <= '0;
      pending_q     <= '0;
      ent_reg_q[0]  <= '0;
      ent_reg_q[1]  <= '0;
      ent_data_q[0] <= '0;
      ent_data_q[1] <= '0;
    end else begin
      live_q    <= 1'b1;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      if (push) begin
        ent_reg_q[wr_ptr_q]  <= bus.md_reg;
        ent_data_q[wr_ptr_q] <= bus.md_data;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (grant_fifo) rd_ptr_q <= ~rd_ptr_q;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve;
  bit   pend [32];
  bit   live;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    live = 1'b0;
  endtask

  task automatic set_idle();
    bus.RegWriteW = 0; bus.WriteRegW = 0; bus.ResultW = 0;
    bus.md_valid = 0; bus.md_reg = 0; bus.md_data = 0;
    bus.issue_valid = 0; bus.issue_reg = 0;
    bus.RsD = 0; bus.RtD = 0; bus.RegWriteD = 0; bus.WriteRegD = 0;
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    logic        fg, sw, we, sd, rdy;
    logic [4:0]  a;
    logic [31:0] d;
    int          n;
    #1;
    n   = q.size();
    rdy = live && (n < 2);
    fg  = (n > 0) && (!bus.RegWriteW || starve == STARVE_MAX);
    sw  = (n > 0) && bus.RegWriteW && (starve == STARVE_MAX);
    a   = fg ? q[0].r : bus.WriteRegW;
    d   = fg ? q[0].d : bus.ResultW;
    we  = live && (fg || bus.RegWriteW) && (a != 0);
    sd  = live && ((bus.RsD != 0 && pend[bus.RsD]) || (bus.RtD != 0 && pend[bus.RtD]) ||
                   (bus.RegWriteD && bus.WriteRegD != 0 && pend[bus.WriteRegD]) ||
                   (bus.issue_valid && bus.issue_reg != 0 && pend[bus.issue_reg]));
    chk("md_ready", 32'(bus.md_ready), 32'(rdy));
    chk("StallD",   32'(bus.StallD),   32'(sd));
    chk("StallW",   32'(bus.StallW),   32'(sw));
    chk("rf_we",    32'(bus.rf_we),    32'(we));
    if (live) begin
      chk("rf_waddr", 32'(bus.rf_waddr), 32'(a));
      chk("rf_wdata", bus.rf_wdata, d);
    end
    @(posedge clk);
    if (n == 0 || fg) starve = 0;
    else if (starve < STARVE_MAX) starve++;
    if (fg) begin
      pend[q[0].r] = 1'b0;
      void'(q.pop_front());
    end
    if (bus.issue_valid && !sd && bus.issue_reg != 0) pend[bus.issue_reg] = 1'b1;
    if (bus.md_valid && rdy) q.push_back('{bus.md_reg, bus.md_data});
    live = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_md_ready", 32'(bus.md_ready), 0);
    chk("rst_rf_we",    32'(bus.rf_we), 0);
    chk("rst_StallD",   32'(bus.StallD), 0);
    chk("rst_StallW",   32'(bus.StallW), 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(bus.md_ready), 1);
    tick();

    // Issue to r8, dependent read stalls, result write releases it
    bus.issue_valid = 1; bus.issue_reg = 8;
    tick();
    bus.issue_valid = 0; bus.RsD = 8;
    #1 chk("raw_stall", 32'(bus.StallD), 1);
    tick();
    bus.md_valid = 1; bus.md_reg = 8; bus.md_data = 32'h1234;
    #1 chk("push_no_same_cycle_we", 32'(bus.rf_we), 0);
    tick();
    bus.md_valid = 0;
    #1;
    chk("md_we",    32'(bus.rf_we), 1);
    chk("md_waddr", 32'(bus.rf_waddr), 8);
    chk("md_wdata", bus.rf_wdata, 32'h1234);
    chk("stall_in_write_cycle", 32'(bus.StallD), 1);
    tick();
    #1 chk("stall_released", 32'(bus.StallD), 0);
    tick();
    set_idle();

    // Starvation: WB wins STARVE_MAX times, then the FIFO head is forced
    bus.md_valid = 1; bus.md_reg = 5; bus.md_data = 32'h5555_0005;
    tick();
    bus.md_valid = 0; bus.RegWriteW = 1; bus.WriteRegW = 3; bus.ResultW = 32'hAAAA_0003;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("starve_StallW", 32'(bus.StallW), (c == 4) ? 1 : 0);
      chk("starve_waddr",  32'(bus.rf_waddr), (c == 4) ? 5 : 3);
      tick();
    end
    set_idle();

    // Back-pressure with WB continuously requesting
    bus.RegWriteW = 1; bus.WriteRegW = 7; bus.ResultW = 32'h7777;
    bus.md_valid = 1;
    for (int c = 0; c < 8; c++) begin
      bus.md_reg = 5'(10 + (c < 2 ? c : 2)); bus.md_data = 32'(100 + c);
      #1;
      if (c == 2) chk("bp_full", 32'(bus.md_ready), 0);
      if (c == 4) chk("bp_pop_cycle_full", 32'(bus.md_ready), 0);
      if (c == 5) chk("bp_ready_after_pop", 32'(bus.md_ready), 1);
      if (c == 5) bus.md_valid = 1;
      if (c == 6) bus.md_valid = 0;
      tick();
    end
    set_idle();
    for (int c = 0; c < 4; c++) tick();

    // Register 0 never writes or stalls
    bus.RegWriteW = 1; bus.WriteRegW = 0; bus.ResultW = 32'hDEAD;
    bus.issue_valid = 1; bus.issue_reg = 0;
    #1 chk("r0_we", 32'(bus.rf_we), 0);
    tick();
    set_idle();
    #1 chk("r0_nostall", 32'(bus.StallD), 0);
    tick();

    // Asynchronous reset with a full FIFO and r9 pending
    bus.issue_valid = 1; bus.issue_reg = 9;
    tick();
    bus.issue_valid = 0; bus.RegWriteW = 1; bus.WriteRegW = 2;
    bus.md_valid = 1; bus.md_reg = 9; bus.md_data = 32'h9999;
    tick();
    bus.md_reg = 4; bus.md_data = 32'h4444;
    tick();
    bus.md_valid = 0; bus.RsD = 9; bus.RegWriteW = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_StallD",   32'(bus.StallD), 0);
    chk("arst_rf_we",    32'(bus.rf_we), 0);
    chk("arst_md_ready", 32'(bus.md_ready), 0);
    chk("arst_StallW",   32'(bus.StallW), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    bus.RsD = 9;
    for (int c = 0; c < 12; c++) begin
      #1 chk("no_write_r9", 32'(bus.rf_we && bus.rf_waddr == 5'd9), 0);
      tick();
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.RegWriteW   = 1'($urandom_range(0, 1));
      bus.WriteRegW   = 5'($urandom_range(0, 7));
      bus.ResultW     = $urandom;
      bus.md_valid    = 1'($urandom_range(0, 2) == 0);
      bus.md_reg      = 5'($urandom_range(0, 7));
      bus.md_data     = $urandom;
      bus.issue_valid = 1'($urandom_range(0, 3) == 0);
      bus.issue_reg   = 5'($urandom_range(0, 7));
      bus.RsD         = 5'($urandom_range(0, 7));
      bus.RtD         = 5'($urandom_range(0, 7));
      bus.RegWriteD   = 1'($urandom_range(0, 1));
      bus.WriteRegD   = 5'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
